// File: rtl/key_pkg.sv
// Shared types and constants for the push-button conditioning block:
// debounce FSM states, key bit positions, default timing and press arbitration.
package key_pkg;

  localparam int NUM_KEYS = 4;

  localparam int KEY_MENU = 0;
  localparam int KEY_L1   = 1;
  localparam int KEY_L2   = 2;
  localparam int KEY_L3   = 3;

  // 20 ms debounce and 1 s tick at a 100 MHz clock.
  localparam int DB_CYCLES_DEFAULT   = 2000000;
  localparam int TICK_CYCLES_DEFAULT = 100000000;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  // Keep only the highest-priority press: menu > level3 > level2 > level1.
  function automatic logic [NUM_KEYS-1:0] arbitrate(input logic [NUM_KEYS-1:0] ev);
    logic [NUM_KEYS-1:0] grant;
    grant = '0;
    if (ev[KEY_MENU])    grant[KEY_MENU] = 1'b1;
    else if (ev[KEY_L3]) grant[KEY_L3]   = 1'b1;
    else if (ev[KEY_L2]) grant[KEY_L2]   = 1'b1;
    else if (ev[KEY_L1]) grant[KEY_L1]   = 1'b1;
    return grant;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button channel: 2-flop synchroniser, debounce FSM with a
// saturating stability counter, debounced level and a single-cycle press event.
module key_debounce
  import key_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_level,
  output logic press_event
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic       sync_meta;
  logic       sync_q;
  key_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its pre-edge inputs; blocking here would collapse the synchroniser to one stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= key_raw;
      sync_q    <= sync_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    press_event = 1'b0;
    case (state_q)
      RELEASED: begin
        if (sync_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync_q) begin
          state_d = RELEASED;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = PRESSED;
          press_event = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PRESSED: begin
        if (!sync_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (sync_q) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASED;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  // A key counts as down until its release has itself been debounced.
  assign key_level = (state_q == PRESSED) || (state_q == RELEASE_WAIT);

endmodule

// File: rtl/key_conditioner.sv
// Four debounced push-buttons with prioritised single-cycle press pulses
// and a free-running seconds tick.
module key_conditioner
  import key_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_DEFAULT,
  parameter int TICK_CYCLES = TICK_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_raw,
  output logic       menu_pulse,
  output logic       level1_pulse,
  output logic       level2_pulse,
  output logic       level3_pulse,
  output logic [3:0] key_level,
  output logic       sec_tick
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  logic [NUM_KEYS-1:0] press_event;
  logic [NUM_KEYS-1:0] pulse_q;
  logic [TW-1:0]       tick_cnt;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_debounce (
      .clk        (clk),
      .rst        (rst),
      .key_raw    (key_raw[k]),
      .key_level  (key_level[k]),
      .press_event(press_event[k])
    );
  end

  // Losing simultaneous presses are dropped, so the register is one-hot or zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pulse_q <= '0;
    else     pulse_q <= arbitrate(press_event);
  end

  assign menu_pulse   = pulse_q[KEY_MENU];
  assign level1_pulse = pulse_q[KEY_L1];
  assign level2_pulse = pulse_q[KEY_L2];
  assign level3_pulse = pulse_q[KEY_L3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    tick_cnt <= '0;
    else if (tick_cnt == TICK_LAST) tick_cnt <= '0;
    else                        tick_cnt <= tick_cnt + TW'(1);
  end

  assign sec_tick = (tick_cnt == TICK_LAST);

endmodule
